ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx.sv | 192 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, start, 8 data bits, odd parity, stop, device ACK.
// Define PS2_TX_RETRY_EN to retry a NACKed or timed-out byte up to twice before reporting failure.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int unsigned MAX_CNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned FLT_W   = $clog2(FILTER_LEN + 1);
`ifdef PS2_TX_RETRY_EN
  localparam logic [1:0]  MAX_RETRY = 2'd2;
`else
  localparam logic [1:0]  MAX_RETRY = 2'd0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_DATA, S_PARITY, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t             state;
  logic               clk_s1, clk_s2, dat_s1, dat_s2;
  logic               clk_f, clk_fd;
  logic [FLT_W-1:0]   flt_cnt;
  logic [TMR_W-1:0]   tmr;
  logic [7:0]         data_q;
  logic               par_q;
  logic [3:0]         idx;
  logic               nack;
  logic [1:0]         attempt;
  logic               fall;
  logic               active;
  logic               tmo;
  logic               fail;

  // Synchronizers plus a run-length glitch filter on the clock line
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      clk_f   <= 1'b1;
      clk_fd  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_s1 <= ps2_clk_i;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat_i;
      dat_s2 <= dat_s1;
      clk_fd <= clk_f;
      if (clk_s2 == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        clk_f   <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall   = clk_fd & ~clk_f;
  assign active = (state == S_START) || (state == S_DATA) || (state == S_PARITY) ||
                  (state == S_ACK) || (state == S_WAIT_IDLE);
  assign tmo    = (tmr == TMR_W'(TIMEOUT_CYCLES - 1));
  // Timeout takes priority over a coincident fall; a NACK completes only once the bus is idle
  assign fail   = (active && tmo) || ((state == S_WAIT_IDLE) && clk_f && dat_s2 && nack);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      tx_ready   <= 1'b1;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ack_ok     <= 1'b0;
      error      <= 1'b0;
      tmr        <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      idx        <= '0;
      nack       <= 1'b0;
      attempt    <= '0;
    end else begin
      done <= 1'b0;
      if (active) tmr <= fall ? '0 : tmr + 1'b1;
      if (fail) begin
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        tmr        <= '0;
        if (attempt != MAX_RETRY) begin
          attempt    <= attempt + 1'b1;
          ps2_clk_oe <= 1'b1;
          state      <= S_INHIBIT;
        end else begin
          done     <= 1'b1;
          error    <= 1'b1;
          ack_ok   <= 1'b0;
          busy     <= 1'b0;
          tx_ready <= 1'b1;
          state    <= S_IDLE;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (tx_valid) begin
              data_q     <= tx_data;
              par_q      <= ~^tx_data;
              busy       <= 1'b1;
              tx_ready   <= 1'b0;
              ack_ok     <= 1'b0;
              error      <= 1'b0;
              attempt    <= '0;
              tmr        <= '0;
              ps2_clk_oe <= 1'b1;
              state      <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (tmr == TMR_W'(INHIBIT_CYCLES - 1)) begin
              tmr        <= '0;
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b1;
              state      <= S_START;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          S_START: begin
            if (fall) begin
              ps2_dat_oe <= ~data_q[0];
              idx        <= 4'd1;
              state      <= S_DATA;
            end
          end
          S_DATA: begin
            if (fall) begin
              if (idx == 4'd8) begin
                ps2_dat_oe <= ~par_q;
                state      <= S_PARITY;
              end else begin
                ps2_dat_oe <= ~data_q[idx[2:0]];
                idx        <= idx + 1'b1;
              end
            end
          end
          S_PARITY: begin
            if (fall) begin
              ps2_dat_oe <= 1'b0;
              state      <= S_ACK;
            end
          end
          S_ACK: begin
            if (fall) begin
              nack  <= dat_s2;
              state <= S_WAIT_IDLE;
            end
          end
          S_WAIT_IDLE: begin
            if (clk_f && dat_s2) begin
              done     <= 1'b1;
              ack_ok   <= 1'b1;
              error    <= 1'b0;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain keyboard model driving the shared lines.
module tb_ps2_host_tx;

  localparam int unsigned INH = 2500;
`ifdef PS2_TX_RETRY_EN
  localparam int unsigned TMO      = 5000;
  localparam int          ATTEMPTS = 3;
`else
  localparam int unsigned TMO      = 50000;
  localparam int          ATTEMPTS = 1;
`endif
  localparam int HALF = 20;

  logic       clk_sys  = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_i, ps2_dat_i, ps2_clk_oe, ps2_dat_oe;
  logic       busy, done, ack_ok, error;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       glitch  = 1'b0;

  // Wired-AND bus: device drive, host open-drain pull-down and injected glitches
  assign ps2_clk_i = dev_clk & ~ps2_clk_oe & ~glitch;
  assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy), .done(done),
    .ack_ok(ack_ok), .error(error)
  );

  always #5 clk_sys = ~clk_sys;

  int   n_cmp = 0, n_err = 0;
  int   inh_cnt = 0, done_cnt = 0;
  logic oe_d = 1'b0;

  always @(negedge clk_sys) begin
    if (done === 1'b1) done_cnt++;
    if (ps2_clk_oe && !oe_d) inh_cnt++;
    oe_d = ps2_clk_oe;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: observed no end of test, expected finish before 10ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk_sys);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk_sys);
    tx_valid = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_ready", tx_ready, 0);
  endtask

  // Keyboard side: measures inhibit, clocks 11 pulses, samples on rising edges
  task automatic dev_xfer(input bit ack, input int stop_after, input bit glitch_en,
                          output logic [7:0] rx, output logic rpar, output logic rstop,
                          output logic rstart, output int inh_len);
    int n;
    n = 0; rx = '0; rpar = 1'b0; rstop = 1'b0; rstart = 1'b1; inh_len = 0;
    while (!ps2_clk_oe && n < 20000) begin @(negedge clk_sys); n++; end
    check("inhibit_seen", ps2_clk_oe, 1);
    while (ps2_clk_oe && inh_len < 20000) begin @(negedge clk_sys); inh_len++; end
    rstart = ps2_dat_i;
    repeat (HALF) @(negedge clk_sys);
    for (int p = 1; p <= 11; p++) begin
      if (p == 11) dev_dat = ~ack;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk_sys);
      if (p == stop_after) return;
      if (p <= 8) rx[3'(p - 1)] = ps2_dat_i;
      else if (p == 9) rpar = ps2_dat_i;
      else if (p == 10) rstop = ps2_dat_i;
      dev_clk = 1'b1;
      if (p == 11) begin
        dev_dat = 1'b1;
        return;
      end
      if (glitch_en) begin
        repeat (10) @(negedge clk_sys);
        glitch = 1'b1;
        repeat (2) @(negedge clk_sys);
        glitch = 1'b0;
        repeat (HALF - 12) @(negedge clk_sys);
      end else begin
        repeat (HALF) @(negedge clk_sys);
      end
    end
  endtask

  task automatic wait_done(input bit exp_ack, input int bound);
    int n;
    n = 0;
    while (done !== 1'b1 && n < bound) begin @(negedge clk_sys); n++; end
    check("done_seen", done, 1);
    check("done_ack_ok", ack_ok, 32'(exp_ack));
    check("done_error", error, 32'(!exp_ack));
    check("done_ready", tx_ready, 1);
    check("done_busy", busy, 0);
    check("done_clk_oe", ps2_clk_oe, 0);
    check("done_dat_oe", ps2_dat_oe, 0);
    @(negedge clk_sys);
    check("done_one_cycle", done, 0);
  endtask

  logic [7:0] rx;
  logic       rpar, rstop, rstart;
  int         inh_len, cyc, inh0, done0, n;

  initial begin
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", {ack_ok, error}, 0);

    // Device traffic while idle is ignored
    for (int i = 0; i < 3; i++) begin
      dev_clk = 1'b0; repeat (HALF) @(negedge clk_sys);
      dev_clk = 1'b1; repeat (HALF) @(negedge clk_sys);
    end
    check("idle_traffic_oe", {ps2_clk_oe, ps2_dat_oe, busy}, 0);

    // 0xED, ACK
    send(8'hED);
    dev_xfer(1'b1, 0, 1'b0, rx, rpar, rstop, rstart, inh_len);
    check("ed_inhibit_len", inh_len, INH);
    check("ed_start", rstart, 0);
    check("ed_data", rx, 8'hED);
    check("ed_parity", rpar, 1);
    check("ed_stop", rstop, 1);
    wait_done(1'b1, 500);

    // 0x07, ACK, parity 0
    send(8'h07);
    dev_xfer(1'b1, 0, 1'b0, rx, rpar, rstop, rstart, inh_len);
    check("07_data", rx, 8'h07);
    check("07_parity", rpar, 0);
    wait_done(1'b1, 500);

    // 0xFF, device never clocks
    inh0 = inh_cnt;
    send(8'hFF);
    n = 0;
    while (ps2_clk_oe && n < 20000) begin @(negedge clk_sys); n++; end
    cyc = 0;
    while (done !== 1'b1 && cyc < 200000) begin @(negedge clk_sys); cyc++; end
`ifndef PS2_TX_RETRY_EN
    check("tmo_cycles", cyc, TMO);
`endif
    wait_done(1'b0, 10);
    check("tmo_attempts", inh_cnt - inh0, ATTEMPTS);

    // 0x00, device NACKs every attempt
    inh0 = inh_cnt; done0 = done_cnt;
    send(8'h00);
    for (int a = 0; a < ATTEMPTS; a++) begin
      dev_xfer(1'b0, 0, 1'b0, rx, rpar, rstop, rstart, inh_len);
      check("nack_data", rx, 8'h00);
      check("nack_parity", rpar, 1);
    end
    wait_done(1'b0, 500);
    check("nack_attempts", inh_cnt - inh0, ATTEMPTS);
    check("nack_single_done", done_cnt - done0, 1);

    // Reset during data bit 4
    done0 = done_cnt;
    send(8'h11);
    dev_xfer(1'b1, 5, 1'b0, rx, rpar, rstop, rstart, inh_len);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    check("mid_rst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ready", tx_ready, 1);
    dev_clk = 1'b1;
    repeat (20) @(negedge clk_sys);
    check("mid_rst_no_done", done_cnt - done0, 0);
    send(8'hA5);
    dev_xfer(1'b1, 0, 1'b0, rx, rpar, rstop, rstart, inh_len);
    check("post_rst_data", rx, 8'hA5);
    wait_done(1'b1, 500);

    // tx_valid held through transfer, clock glitches injected
    inh0 = inh_cnt;
    @(negedge clk_sys);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(negedge clk_sys);
    tx_data  = 8'h5A;
    dev_xfer(1'b1, 0, 1'b1, rx, rpar, rstop, rstart, inh_len);
    check("glitch_data", rx, 8'h3C);
    check("glitch_parity", rpar, 1);
    check("glitch_stop", rstop, 1);
    check("glitch_one_byte", inh_cnt - inh0, 1);
    wait_done(1'b1, 500);
    check("second_accept", busy, 1);
    tx_valid = 1'b0;
    dev_xfer(1'b1, 0, 1'b0, rx, rpar, rstop, rstart, inh_len);
    check("second_data", rx, 8'h5A);
    wait_done(1'b1, 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
